// File: rtl/divider_counter_if.sv
// rtl/divider_counter_if.sv - reload/control inputs and count/pulse outputs of the divider counter
//
// Signals:
//   D        reload value (8 bits), sampled only at load or terminal-count reload
//   DN       direction select: 1 = count up, 0 = count down
//   preset_n parallel load, synchronous, active-low
//   Q        live count value (8 bits)
//   out      divided output, one-cycle pulse per period
//
// Modports:
//   master  drives D/DN/preset_n, observes Q/out (stimulus or upstream control)
//   slave   the counter itself
interface divider_counter_if;
    logic [7:0] D;
    logic       DN;
    logic       preset_n;
    logic [7:0] Q;
    logic       out;

    modport master (
        output D,
        output DN,
        output preset_n,
        input  Q,
        input  out
    );

    modport slave (
        input  D,
        input  DN,
        input  preset_n,
        output Q,
        output out
    );
endinterface

// File: rtl/divider_counter.sv
// rtl/divider_counter.sv - programmable 8-bit reload counter dividing the oscillator clock
//
// Ports:
//   clk  in   count clock (oscillator output), rising-edge active
//   rst  in   synchronous active-high reset
//   bus  slave modport of divider_counter_if:
//          D[7:0] reload value, DN direction (1 = up), preset_n load (active-low),
//          Q[7:0] current count, out one-cycle pulse per divided period
//
// Up mode divides by 256-D, down mode by D+1. The terminal value (0xFF up,
// 0x00 down) never wraps; it reloads from D and pulses out for one cycle.
module divider_counter (
    input  logic               clk,
    input  logic               rst,
    divider_counter_if.slave   bus
);

    logic [7:0] count;
    logic       pulse;

    // Terminal detection depends on direction so the count can turn around
    // mid-period without a reload: the new direction only changes which end
    // of the range triggers the next reload.
    logic at_terminal;
    assign at_terminal = bus.DN ? (count == 8'hFF) : (count == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'h00;
            pulse <= 1'b0;
        end else if (!bus.preset_n) begin
            // Held load restarts the period and suppresses any pending pulse.
            count <= bus.D;
            pulse <= 1'b0;
        end else if (at_terminal) begin
            count <= bus.D;
            pulse <= 1'b1;
        end else begin
            count <= bus.DN ? (count + 8'd1) : (count - 8'd1);
            pulse <= 1'b0;
        end
    end

    // Both outputs come straight from flops; no input reaches them combinationally.
    assign bus.Q   = count;
    assign bus.out = pulse;

endmodule

// File: tb/tb_divider_counter.sv
// tb/tb_divider_counter.sv - self-checking bench for divider_counter
module tb_divider_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    divider_counter_if bus ();

    divider_counter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] q;
        logic       o;
    } exp_t;

    exp_t sb[$];

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] mq    = 8'h00;
    logic       mout  = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: predict the next state from the inputs now being driven,
    // queue it, let the edge happen, then pop and compare against the DUT.
    task automatic step();
        exp_t e;
        if (rst) begin
            mq = 8'h00; mout = 1'b0;
        end else if (!bus.preset_n) begin
            mq = bus.D; mout = 1'b0;
        end else if (bus.DN) begin
            if (mq == 8'hFF) begin mq = bus.D; mout = 1'b1; end
            else begin mq = mq + 8'd1; mout = 1'b0; end
        end else begin
            if (mq == 8'h00) begin mq = bus.D; mout = 1'b1; end
            else begin mq = mq - 8'd1; mout = 1'b0; end
        end
        e.q = mq;
        e.o = mout;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        e = sb.pop_front();
        total++;
        assert (bus.Q === e.q && bus.out === e.o) else begin
            bad++;
            $error("FAIL scoreboard cyc=%0d observed Q=%h out=%b expected Q=%h out=%b",
                   cyc, bus.Q, bus.out, e.q, e.o);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Counts edges until out is seen high; a missing pulse is a failure.
    task automatic wait_pulse(input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.out !== 1'b1 && n < maxc);
        if (bus.out !== 1'b1) chk("pulse_timeout", n, -1);
    endtask

    task automatic load(input logic [7:0] d, input logic dn, input int cycles);
        bus.D = d;
        bus.DN = dn;
        bus.preset_n = 1'b0;
        steps(cycles);
        bus.preset_n = 1'b1;
    endtask

    int n;
    logic [7:0] down_seq [5];

    initial begin
        bus.D = 8'h00;
        bus.DN = 1'b1;
        bus.preset_n = 1'b1;
        rst = 1'b1;
        steps(2);
        chk("reset_q", int'(bus.Q), 0);
        chk("reset_out", int'(bus.out), 0);
        rst = 1'b0;

        // Divide by 103
        load(8'h99, 1'b1, 2);
        chk("load_q", int'(bus.Q), 'h99);
        wait_pulse(400, n);
        chk("div103_first", n, 103);
        chk("div103_pulse_q", int'(bus.Q), 'h99);
        wait_pulse(400, n);
        chk("div103_second", n, 103);
        step();
        chk("pulse_width", int'(bus.out), 0);

        // Reload-value change mid-period: current period keeps 103
        steps(9);
        bus.D = 8'hF0;
        wait_pulse(400, n);
        chk("dchange_period", n + 10, 103);
        chk("dchange_pulse_q", int'(bus.Q), 'hF0);
        wait_pulse(400, n);
        chk("div16", n, 16);

        // Mid-period preset while Q=0xC0
        load(8'h99, 1'b1, 1);
        steps(8'hC0 - 8'h99);
        chk("pre_q_c0", int'(bus.Q), 'hC0);
        bus.preset_n = 1'b0;
        step();
        bus.preset_n = 1'b1;
        chk("midpreset_q", int'(bus.Q), 'h99);
        chk("midpreset_out", int'(bus.out), 0);
        wait_pulse(400, n);
        chk("midpreset_period", n, 103);

        // Down mode D=4: 4,3,2,1,0,4
        load(8'h04, 1'b0, 1);
        chk("down_load", int'(bus.Q), 4);
        down_seq = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd4};
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("down_seq%0d", i), int'(bus.Q), int'(down_seq[i]));
        end
        chk("down_pulse", int'(bus.out), 1);
        wait_pulse(50, n);
        chk("down_period", n, 5);

        // Degenerate up: D=0xFF
        load(8'hFF, 1'b1, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("degen_up_out%0d", i), int'(bus.out), 1);
            chk($sformatf("degen_up_q%0d", i), int'(bus.Q), 'hFF);
        end

        // Degenerate down: D=0x00
        load(8'h00, 1'b0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("degen_dn_out%0d", i), int'(bus.out), 1);
        end

        // Direction change mid-period continues from current Q
        load(8'h10, 1'b1, 1);
        steps(5);
        bus.DN = 1'b0;
        steps(3);
        chk("dir_change_q", int'(bus.Q), 'h12);

        // Reset has priority over preset; up mode then needs 256 cycles
        load(8'h99, 1'b1, 1);
        steps(20);
        rst = 1'b1;
        bus.preset_n = 1'b0;
        step();
        chk("rst_prio_q", int'(bus.Q), 0);
        chk("rst_prio_out", int'(bus.out), 0);
        rst = 1'b0;
        bus.preset_n = 1'b1;
        wait_pulse(600, n);
        chk("post_rst_first", n, 256);
        wait_pulse(400, n);
        chk("post_rst_second", n, 103);

        // Down mode after reset: first edge reloads and pulses
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.DN = 1'b0;
        bus.D = 8'h07;
        step();
        chk("down_after_rst_out", int'(bus.out), 1);
        chk("down_after_rst_q", int'(bus.Q), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
